player_spd: RTL and testbench

- Per-frame player velocity stage of the game core. It sits directly upstream of the combinational position/remainder integrator.
- On each frame tick it takes button state, ground contact and the integrator's fed-back speed. It applies run acceleration, gravity, jump (with jump buffer and coyote grace) and dash.
- It registers the new speed, which the integrator consumes on the following cycle.
- All speeds are signed 16.16 fixed point (vec2d fields); all arithmetic is 32-bit two's complement.

---
 rtl/player_spd.sv | 206 ++++++++++++++++++++
 tb/tb_player_spd.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/player_spd.sv
// Per-frame player velocity stage: run acceleration, gravity, buffered/coyote jump
// and dash steering. Produces the speed the position integrator consumes next cycle.
package player_spd_pkg;
  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
  } vec2d;
endpackage

module player_spd
  import player_spd_pkg::*;
#(
  parameter logic signed [31:0] MAXRUN       = 32'sh0001_0000,
  parameter logic signed [31:0] ACC_GND      = 32'sh0000_9999,
  parameter logic signed [31:0] ACC_AIR      = 32'sh0000_6666,
  parameter logic signed [31:0] DECEL        = 32'sh0000_2666,
  parameter logic signed [31:0] MAXFALL      = 32'sh0002_0000,
  parameter logic signed [31:0] GRAV         = 32'sh0000_35C2,
  parameter logic signed [31:0] JUMP_SPD     = 32'shFFFE_0000,
  parameter logic signed [31:0] DASH_FULL    = 32'sh0005_0000,
  parameter logic signed [31:0] DASH_DIAG    = 32'sh0003_8918,
  parameter int unsigned        DASH_FRAMES  = 4,
  parameter int unsigned        BUF_FRAMES   = 4,
  parameter int unsigned        GRACE_FRAMES = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic [5:0] btn_i,
  input  logic       on_ground_i,
  input  vec2d       spd_i,
  output vec2d       spd_o,
  output logic       spd_valid_o,
  output logic       dashing_o,
  output logic       djump_o,
  output logic       facing_o
);

  localparam logic signed [31:0] DT_FULL   = 32'sh0002_0000;
  localparam logic signed [31:0] DT_UPDIAG = 32'sh0001_8000;
  localparam logic signed [31:0] STEER     = 32'sh0001_8000;
  localparam logic signed [31:0] SLOW_BAND = 32'sh0000_2666;

  // |v| with the most negative value saturating instead of wrapping
  function automatic logic signed [31:0] sat_abs(input logic signed [31:0] v);
    if (v == 32'sh8000_0000) return 32'sh7FFF_FFFF;
    else if (v < 0)          return -v;
    else                     return v;
  endfunction

  // Move v toward t by step a (a >= 0), never passing t; 33-bit math avoids wrap
  function automatic logic signed [31:0] appr(input logic signed [31:0] v,
                                              input logic signed [31:0] t,
                                              input logic signed [31:0] a);
    logic signed [32:0] r;
    logic signed [32:0] t33;
    t33 = $signed({t[31], t});
    if (v < t) begin
      r = $signed({v[31], v}) + $signed({a[31], a});
      if (r > t33) return t;
      else         return r[31:0];
    end else if (v > t) begin
      r = $signed({v[31], v}) - $signed({a[31], a});
      if (r < t33) return t;
      else         return r[31:0];
    end else begin
      return t;
    end
  endfunction

  vec2d               spd_q, spd_d;
  logic               valid_q, valid_d;
  logic [2:0]         dash_t_q, dash_t_d;
  logic [2:0]         grace_q, grace_d;
  logic [2:0]         jbuf_q, jbuf_d;
  logic               djump_q, djump_d;
  logic               facing_q, facing_d;
  logic               jump_prev_q, jump_prev_d;
  logic               dash_prev_q, dash_prev_d;
  logic signed [31:0] dtx_q, dtx_d;
  logic signed [31:0] dty_q, dty_d;

  vec2d               s;
  logic               jump_press, dash_press;
  logic               dir_r, dir_l, dir_u, dir_d, has_x, has_y;
  logic signed [31:0] in_tgt, acc, grav, mag;

  always_comb begin
    spd_d       = spd_q;
    valid_d     = frame_tick_i;
    dash_t_d    = dash_t_q;
    grace_d     = grace_q;
    jbuf_d      = jbuf_q;
    djump_d     = djump_q;
    facing_d    = facing_q;
    jump_prev_d = jump_prev_q;
    dash_prev_d = dash_prev_q;
    dtx_d       = dtx_q;
    dty_d       = dty_q;
    s           = spd_i;
    jump_press  = btn_i[4] & ~jump_prev_q;
    dash_press  = btn_i[5] & ~dash_prev_q;
    dir_r       = btn_i[1] & ~btn_i[0];
    dir_l       = btn_i[0] & ~btn_i[1];
    dir_d       = btn_i[3] & ~btn_i[2];
    dir_u       = btn_i[2] & ~btn_i[3];
    has_x       = 1'b0;
    has_y       = 1'b0;
    in_tgt      = '0;
    acc         = '0;
    grav        = '0;
    mag         = '0;

    if (frame_tick_i) begin
      jump_prev_d = btn_i[4];
      dash_prev_d = btn_i[5];

      if (on_ground_i) begin
        grace_d = 3'(GRACE_FRAMES);
        djump_d = 1'b1;
      end else if (grace_q != 3'd0) begin
        grace_d = grace_q - 3'd1;
      end

      if (jump_press)              jbuf_d = 3'(BUF_FRAMES);
      else if (jbuf_q != 3'd0)     jbuf_d = jbuf_q - 3'd1;

      if (dir_r) facing_d = 1'b0;
      if (dir_l) facing_d = 1'b1;

      if (dash_t_q != 3'd0) begin
        dash_t_d = dash_t_q - 3'd1;
        s.x = appr(s.x, dtx_q, STEER);
        s.y = appr(s.y, dty_q, STEER);
      end else begin
        in_tgt = dir_r ? MAXRUN : (dir_l ? -MAXRUN : 32'sh0);
        acc    = on_ground_i ? ACC_GND : ACC_AIR;
        if (sat_abs(s.x) > MAXRUN) s.x = appr(s.x, (s.x < 0) ? -MAXRUN : MAXRUN, DECEL);
        else                       s.x = appr(s.x, in_tgt, acc);

        grav = (sat_abs(s.y) <= SLOW_BAND) ? (GRAV >>> 1) : GRAV;
        if (!on_ground_i) s.y = appr(s.y, MAXFALL, grav);

        if ((jbuf_d != 3'd0) && (grace_d != 3'd0)) begin
          s.y     = JUMP_SPD;
          jbuf_d  = 3'd0;
          grace_d = 3'd0;
        end else if (dash_press && djump_d) begin
          // No arrow held: dash horizontally in the facing direction
          if (!(dir_r | dir_l | dir_u | dir_d)) begin
            dir_r = ~facing_d;
            dir_l = facing_d;
          end
          has_x = dir_r | dir_l;
          has_y = dir_u | dir_d;
          mag   = (has_x && has_y) ? DASH_DIAG : DASH_FULL;
          s.x   = dir_r ? mag : (dir_l ? -mag : 32'sh0);
          s.y   = dir_d ? mag : (dir_u ? -mag : 32'sh0);
          dtx_d = dir_r ? DT_FULL : (dir_l ? -DT_FULL : 32'sh0);
          dty_d = dir_d ? DT_FULL : (dir_u ? (has_x ? -DT_UPDIAG : -DT_FULL) : 32'sh0);
          djump_d  = 1'b0;
          dash_t_d = 3'(DASH_FRAMES);
          jbuf_d   = 3'd0;
        end
      end
      spd_d = s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spd_q       <= '0;
      valid_q     <= 1'b0;
      dash_t_q    <= 3'd0;
      grace_q     <= 3'd0;
      jbuf_q      <= 3'd0;
      djump_q     <= 1'b1;
      facing_q    <= 1'b0;
      jump_prev_q <= 1'b0;
      dash_prev_q <= 1'b0;
    end else begin
      spd_q       <= spd_d;
      valid_q     <= valid_d;
      dash_t_q    <= dash_t_d;
      grace_q     <= grace_d;
      jbuf_q      <= jbuf_d;
      djump_q     <= djump_d;
      facing_q    <= facing_d;
      jump_prev_q <= jump_prev_d;
      dash_prev_q <= dash_prev_d;
    end
  end

  // Dash targets are only read while the dash timer is running
  always_ff @(posedge clk_i) begin
    dtx_q <= dtx_d;
    dty_q <= dty_d;
  end

  assign spd_o       = spd_q;
  assign spd_valid_o = valid_q;
  assign dashing_o   = (dash_t_q != 3'd0);
  assign djump_o     = djump_q;
  assign facing_o    = facing_q;

endmodule

// File: tb/tb_player_spd.sv
// Directed bench for player_spd: a table of consecutive frames with hand-computed
// speeds and flags, plus reset and valid-pulse sequences.
module tb_player_spd;
  import player_spd_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [5:0] btn;
  logic       on_ground;
  vec2d       spd_in;
  vec2d       spd_out;
  logic       spd_valid, dashing, djump, facing;

  int n_checks = 0;
  int n_pass   = 0;

  player_spd dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .frame_tick_i (frame_tick),
    .btn_i        (btn),
    .on_ground_i  (on_ground),
    .spd_i        (spd_in),
    .spd_o        (spd_out),
    .spd_valid_o  (spd_valid),
    .dashing_o    (dashing),
    .djump_o      (djump),
    .facing_o     (facing)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] B_L = 6'd1, B_R = 6'd2, B_U = 6'd4, B_J = 6'd16, B_DS = 6'd32;

  typedef struct {
    logic [5:0]  btn;
    logic        gnd;
    logic [31:0] sx, sy;
    logic [31:0] ex, ey;
    logic        edash, edj, efc;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    tbl[0]  = '{B_R,          1'b1, 32'h0,        32'h0,        32'h00009999, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[1]  = '{6'd0,         1'b0, 32'h0,        32'h00010000, 32'h0,        32'h000135C2, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{6'd0,         1'b0, 32'h0,        32'h00001000, 32'h0,        32'h00002AE1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{6'd0,         1'b0, 32'h00018000, 32'h0,        32'h0001599A, 32'h00001AE1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{6'd0,         1'b0, 32'h0,        32'h00020000, 32'h0,        32'h00020000, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{B_J,          1'b0, 32'h0,        32'h0,        32'h0,        32'hFFFE0000, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{6'd0,         1'b0, 32'h0,        32'h0,        32'h0,        32'h00001AE1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{B_J,          1'b0, 32'h0,        32'h0,        32'h0,        32'h00001AE1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{6'd0,         1'b0, 32'h0,        32'h0,        32'h0,        32'h00001AE1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{6'd0,         1'b1, 32'h0,        32'h0,        32'h0,        32'hFFFE0000, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{6'd0,         1'b1, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    tbl[11] = '{B_L,          1'b0, 32'h0,        32'h0,        32'hFFFF999A, 32'h00001AE1, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{B_L | B_R,    1'b0, 32'hFFFF999A, 32'h0,        32'h0,        32'h00001AE1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{6'd0,         1'b0, 32'h80000000, 32'h0,        32'h80002666, 32'h00001AE1, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{B_R,          1'b0, 32'h00010000, 32'h0,        32'h00010000, 32'h00001AE1, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{6'd0,         1'b0, 32'h0,        32'h0,        32'h0,        32'h00001AE1, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{6'd0,         1'b0, 32'h0,        32'h0,        32'h0,        32'h00001AE1, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{B_J,          1'b0, 32'h0,        32'h0,        32'h0,        32'h00001AE1, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{B_DS|B_U|B_R, 1'b0, 32'h0,        32'h0,        32'h00038918, 32'hFFFC76E8, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{B_DS|B_U|B_R, 1'b0, 32'h00038918, 32'hFFFC76E8, 32'h00020918, 32'hFFFDF6E8, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{6'd0,         1'b0, 32'h00020918, 32'hFFFDF6E8, 32'h00020000, 32'hFFFE8000, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{B_DS,         1'b0, 32'h00020000, 32'hFFFE8000, 32'h00020000, 32'hFFFE8000, 1'b1, 1'b0, 1'b0};
    tbl[22] = '{6'd0,         1'b0, 32'h00020000, 32'hFFFE8000, 32'h00020000, 32'hFFFE8000, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{B_DS,         1'b0, 32'h0,        32'h0,        32'h0,        32'h00001AE1, 1'b0, 1'b0, 1'b0};
    tbl[24] = '{6'd0,         1'b1, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    tbl[25] = '{B_DS,         1'b1, 32'h0,        32'h0,        32'h00050000, 32'h0,        1'b1, 1'b0, 1'b0};

    rst        = 1'b1;
    frame_tick = 1'b0;
    btn        = '0;
    on_ground  = 1'b0;
    spd_in     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset spd_x",  spd_out.x, 32'h0);
    chk("reset spd_y",  spd_out.y, 32'h0);
    chk("reset valid",  {31'd0, spd_valid}, 32'd0);
    chk("reset dashing",{31'd0, dashing}, 32'd0);
    chk("reset djump",  {31'd0, djump}, 32'd1);
    chk("reset facing", {31'd0, facing}, 32'd0);

    for (int i = 0; i < 26; i++) begin
      btn        = tbl[i].btn;
      on_ground  = tbl[i].gnd;
      spd_in.x   = tbl[i].sx;
      spd_in.y   = tbl[i].sy;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      chk($sformatf("v%0d spd_x", i),   spd_out.x, tbl[i].ex);
      chk($sformatf("v%0d spd_y", i),   spd_out.y, tbl[i].ey);
      chk($sformatf("v%0d valid", i),   {31'd0, spd_valid}, 32'd1);
      chk($sformatf("v%0d dashing", i), {31'd0, dashing}, {31'd0, tbl[i].edash});
      chk($sformatf("v%0d djump", i),   {31'd0, djump},   {31'd0, tbl[i].edj});
      chk($sformatf("v%0d facing", i),  {31'd0, facing},  {31'd0, tbl[i].efc});
      // Idle cycle: pulse drops and nothing moves even with changed inputs
      btn      = 6'h3F;
      spd_in.x = 32'h12345678;
      @(negedge clk);
      chk($sformatf("v%0d valid_drop", i), {31'd0, spd_valid}, 32'd0);
      chk($sformatf("v%0d hold_x", i),     spd_out.x, tbl[i].ex);
      chk($sformatf("v%0d hold_dash", i),  {31'd0, dashing}, {31'd0, tbl[i].edash});
      btn = tbl[i].btn;
    end

    // Mid-dash reset with a coincident frame tick: tick is dropped
    btn        = B_R;
    on_ground  = 1'b0;
    spd_in.x   = 32'h00050000;
    spd_in.y   = 32'h0;
    rst        = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    frame_tick = 1'b0;
    chk("rst_dash spd_x",   spd_out.x, 32'h0);
    chk("rst_dash spd_y",   spd_out.y, 32'h0);
    chk("rst_dash valid",   {31'd0, spd_valid}, 32'd0);
    chk("rst_dash dashing", {31'd0, dashing}, 32'd0);
    chk("rst_dash djump",   {31'd0, djump}, 32'd1);

    // After reset the dash timer is clear, so a tick runs ordinary air physics
    btn        = 6'd0;
    spd_in     = '0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("post_rst spd_x",   spd_out.x, 32'h0);
    chk("post_rst spd_y",   spd_out.y, 32'h00001AE1);
    chk("post_rst dashing", {31'd0, dashing}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
